md_scheduler: RTL and testbench

Multiply/divide scheduler for the five-stage pipeline: owns the HI/LO registers and sequences mult/multu/div/divu with fixed multi-cycle latency. It sits beside the E-stage ALU, accepts operations from E, and asserts a D-stage stall request to the hazard controller. The stall request is raised whenever an instruction in D touches HI/LO while the unit is busy or starting. mfhi/mflo read the HI/LO outputs directly; forwarding into D/E operands stays with the forwarding controller.

---
 rtl/md_scheduler_if.sv | 37 +++
 rtl/md_scheduler.sv | 131 +++++++++++++
 tb/tb_md_scheduler.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/md_scheduler_if.sv
// rtl/md_scheduler_if.sv - E/D-stage handshake bundle for the multiply/divide scheduler
//
// Purpose: groups the E-stage request, D-stage query and HI/LO result signals
// shared between the pipeline and md_scheduler.
// Signals:
//   E_Start   pipeline -> unit  E-stage instruction is mult/multu/div/divu
//   E_Write   pipeline -> unit  E-stage instruction is mthi/mtlo
//   E_MDOp    pipeline -> unit  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo
//   E_A, E_B  pipeline -> unit  forwarded rs/rt operands
//   E_Cancel  pipeline -> unit  flush of the E-stage instruction this cycle
//   D_UseMD   pipeline -> unit  D-stage instruction touches HI/LO
//   Busy      unit -> pipeline  operation in flight
//   Stall     unit -> pipeline  D-stage stall request
//   HI, LO    unit -> pipeline  architectural HI/LO registers
interface md_scheduler_if;
  logic        E_Start;
  logic        E_Write;
  logic [2:0]  E_MDOp;
  logic [31:0] E_A;
  logic [31:0] E_B;
  logic        E_Cancel;
  logic        D_UseMD;
  logic        Busy;
  logic        Stall;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output E_Start, E_Write, E_MDOp, E_A, E_B, E_Cancel, D_UseMD,
    input  Busy, Stall, HI, LO
  );

  modport slave (
    input  E_Start, E_Write, E_MDOp, E_A, E_B, E_Cancel, D_UseMD,
    output Busy, Stall, HI, LO
  );
endinterface

// File: rtl/md_scheduler.sv
// rtl/md_scheduler.sv - HI/LO owner and fixed-latency mult/div sequencer
//
// Purpose: accepts mult/multu/div/divu from E, computes the result at the
// accept edge into pending registers, holds Busy for a fixed number of cycles
// and then commits to HI/LO. mthi/mtlo write HI/LO directly when idle.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   md     md_scheduler_if.slave (E request, D query, Busy/Stall/HI/LO)
module md_scheduler #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic           clk,
  input  logic           reset,
  md_scheduler_if.slave  md
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_RAW    = $clog2(MAX_CYCLES + 1);
  localparam int CNT_W      = (CNT_RAW < 4) ? 4 : CNT_RAW;
  localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      phi_q, phi_d, plo_q, plo_d;
  logic             dz_q, dz_d;

  logic        is_mul, is_signed, start_ok, write_ok, busy;
  logic        neg_a, neg_b;
  logic [63:0] mul_a, mul_b, prod;
  logic [31:0] mag_a, mag_b, div_b, q_u, r_u, quo, rem;

  // Arithmetic datapath, evaluated on the current E operands.
  always_comb begin
    is_mul    = (md.E_MDOp == 3'd0) || (md.E_MDOp == 3'd1);
    is_signed = (md.E_MDOp == 3'd0) || (md.E_MDOp == 3'd2);

    // Sign/zero extension to 64 bits makes one unsigned multiplier serve both.
    mul_a = {{32{is_signed & md.E_A[31]}}, md.E_A};
    mul_b = {{32{is_signed & md.E_B[31]}}, md.E_B};
    prod  = mul_a * mul_b;

    // Signed divide via magnitudes: avoids the 0x80000000 / -1 overflow case
    // and gives truncation toward zero with the remainder following the dividend.
    neg_a = is_signed & md.E_A[31];
    neg_b = is_signed & md.E_B[31];
    mag_a = neg_a ? (~md.E_A + 32'd1) : md.E_A;
    mag_b = neg_b ? (~md.E_B + 32'd1) : md.E_B;
    div_b = (md.E_B == 32'd0) ? 32'd1 : mag_b;
    q_u   = mag_a / div_b;
    r_u   = mag_a % div_b;
    quo   = (neg_a ^ neg_b) ? (~q_u + 32'd1) : q_u;
    rem   = neg_a ? (~r_u + 32'd1) : r_u;
  end

  always_comb begin
    start_ok = (state_q == IDLE) && md.E_Start && !md.E_Cancel && (md.E_MDOp <= 3'd3);
    // E_Start takes priority, so a simultaneous E_Write is dropped.
    write_ok = (state_q == IDLE) && !md.E_Start && md.E_Write && !md.E_Cancel &&
               ((md.E_MDOp == 3'd4) || (md.E_MDOp == 3'd5));

    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    dz_d    = dz_q;

    case (state_q)
      IDLE: begin
        if (start_ok) begin
          phi_d   = is_mul ? prod[63:32] : rem;
          plo_d   = is_mul ? prod[31:0]  : quo;
          dz_d    = !is_mul && (md.E_B == 32'd0);
          cnt_d   = is_mul ? MULT_LD : DIV_LD;
          state_d = BUSY;
        end else if (write_ok) begin
          if (md.E_MDOp == 3'd4) hi_d = md.E_A;
          else                   lo_d = md.E_A;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          // A divide by zero still burns the full latency but leaves HI/LO intact.
          if (!dz_q) begin
            hi_d = phi_q;
            lo_d = plo_q;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      phi_q   <= '0;
      plo_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
      dz_q    <= dz_d;
    end
  end

  assign busy     = (state_q == BUSY);
  assign md.Busy  = busy;
  // Covers the start cycle too, so a dependent D instruction never slips past.
  assign md.Stall = md.D_UseMD & (busy | (md.E_Start & ~md.E_Cancel));
  assign md.HI    = hi_q;
  assign md.LO    = lo_q;

endmodule

// File: tb/tb_md_scheduler.sv
// tb/tb_md_scheduler.sv - scoreboard bench for md_scheduler
module tb_md_scheduler;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  md_scheduler_if mif();

  md_scheduler #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (rst_n),
    .md    (mif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] ch,
                                        input logic [31:0] cl);
    longint sa, sb, p, q, r;
    logic [63:0] u;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      3'd0: begin p = sa * sb; return p; end
      3'd1: begin u = {32'd0, a} * {32'd0, b}; return u; end
      3'd2: begin
        if (b == 32'd0) return {ch, cl};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return {ch, cl};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Drives a start at a negedge; the following posedge accepts it.
  task automatic drive_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit push);
    exp_t        e;
    logic [63:0] r;
    mif.E_Start = 1'b1;
    mif.E_MDOp  = op;
    mif.E_A     = a;
    mif.E_B     = b;
    if (push) begin
      r     = model(op, a, b, m_hi, m_lo);
      e.hi  = r[63:32];
      e.lo  = r[31:0];
      e.cyc = (op < 3'd2) ? 5 : 10;
      m_hi  = e.hi;
      m_lo  = e.lo;
      sb_q.push_back(e);
    end
    #1;
    if (mif.D_UseMD) chk("stall_start", mif.Stall, 1);
    @(negedge clk);
    mif.E_Start = 1'b0;
    mif.E_Write = 1'b0;
  endtask

  task automatic wait_done(input bit check_stall);
    int   n;
    exp_t e;
    n = 0;
    while (mif.Busy && n < 60) begin
      if (check_stall) chk("stall_busy", mif.Stall, 1);
      n++;
      @(negedge clk);
    end
    if (n >= 60) chk("busy_timeout", n, 0);
    if (check_stall) chk("stall_idle", mif.Stall, 0);
    if (sb_q.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      e = sb_q.pop_front();
      chk("busy_len", n, e.cyc);
      chk("hi", mif.HI, e.hi);
      chk("lo", mif.LO, e.lo);
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    m_hi         = 32'd0;
    m_lo         = 32'd0;
    rst_n        = 1'b0;
    mif.E_Start  = 1'b0;
    mif.E_Write  = 1'b0;
    mif.E_MDOp   = 3'd0;
    mif.E_A      = 32'd0;
    mif.E_B      = 32'd0;
    mif.E_Cancel = 1'b0;
    mif.D_UseMD  = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_busy", mif.Busy, 0);
    chk("rst_hi", mif.HI, 0);
    chk("rst_lo", mif.LO, 0);
    mif.D_UseMD = 1'b1;
    #1 chk("rst_stall", mif.Stall, 0);
    mif.D_UseMD = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic mult with a dependent instruction waiting in D.
    mif.D_UseMD = 1'b1;
    drive_op(3'd0, 32'hFFFF_FFFE, 32'd3, 1);
    wait_done(1);
    mif.D_UseMD = 1'b0;

    drive_op(3'd1, 32'hFFFF_FFFF, 32'd2, 1);
    wait_done(0);
    drive_op(3'd3, 32'd7, 32'd2, 1);
    wait_done(0);
    drive_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1);
    wait_done(0);
    drive_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    wait_done(0);
    drive_op(3'd2, 32'd123, 32'd0, 1);
    wait_done(0);
    drive_op(3'd3, 32'd55, 32'd0, 1);
    wait_done(0);

    // Start and write together: the start wins.
    mif.E_Write = 1'b1;
    drive_op(3'd0, 32'd6, 32'd7, 1);
    wait_done(0);

    // Cancelled start.
    mif.D_UseMD  = 1'b1;
    mif.E_Start  = 1'b1;
    mif.E_Cancel = 1'b1;
    mif.E_MDOp   = 3'd0;
    mif.E_A      = 32'd9;
    mif.E_B      = 32'd9;
    #1 chk("cancel_stall", mif.Stall, 0);
    @(negedge clk);
    mif.E_Start  = 1'b0;
    mif.E_Cancel = 1'b0;
    mif.D_UseMD  = 1'b0;
    chk("cancel_busy", mif.Busy, 0);
    chk("cancel_hi", mif.HI, m_hi);
    chk("cancel_lo", mif.LO, m_lo);

    // Invalid opcodes.
    mif.E_Start = 1'b1;
    mif.E_MDOp  = 3'd6;
    mif.E_A     = 32'hDEAD_BEEF;
    @(negedge clk);
    mif.E_Start = 1'b0;
    mif.E_Write = 1'b1;
    mif.E_MDOp  = 3'd7;
    @(negedge clk);
    mif.E_Write = 1'b0;
    chk("inv_busy", mif.Busy, 0);
    chk("inv_hi", mif.HI, m_hi);
    chk("inv_lo", mif.LO, m_lo);

    // mthi / mtlo.
    mif.E_Write = 1'b1;
    mif.E_MDOp  = 3'd4;
    mif.E_A     = 32'h1234_5678;
    @(negedge clk);
    chk("mthi", mif.HI, 32'h1234_5678);
    chk("mthi_lo", mif.LO, m_lo);
    m_hi        = 32'h1234_5678;
    mif.E_MDOp  = 3'd5;
    mif.E_A     = 32'hCAFE_F00D;
    @(negedge clk);
    mif.E_Write = 1'b0;
    chk("mtlo", mif.LO, 32'hCAFE_F00D);
    chk("mtlo_hi", mif.HI, m_hi);
    m_lo        = 32'hCAFE_F00D;
    chk("mt_busy", mif.Busy, 0);

    // Random back-to-back operations.
    for (int i = 0; i < 8; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = 3'($urandom_range(0, 3));
      a  = $urandom;
      b  = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      drive_op(op, a, b, 1);
      wait_done(0);
    end

    // Async reset in the middle of a divide, then a clean mult.
    drive_op(3'd2, 32'd100, 32'd7, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", mif.Busy, 0);
    chk("arst_hi", mif.HI, 0);
    chk("arst_lo", mif.LO, 0);
    m_hi = 32'd0;
    m_lo = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive_op(3'd0, 32'd6, 32'd7, 1);
    wait_done(0);

    chk("sb_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
